// File: rtl/param_updown_counter.sv
// rtl/param_updown_counter.sv - parametrised up/down counter with bounds, step, load and sticky flags
// Optional bounce mode (MODE 10) is built only when UPDN_CNT_BOUNCE_EN is defined.
module param_updown_counter #(
  parameter int WIDTH  = 8,
  parameter int STEP_W = 4
) (
  input  logic              CLK,
  input  logic              N_RST,
  input  logic              EN,
  input  logic              UP_DWN,
  input  logic              LOAD,
  input  logic [WIDTH-1:0]  LOAD_VAL,
  input  logic [STEP_W-1:0] STEP,
  input  logic [WIDTH-1:0]  MIN_VAL,
  input  logic [WIDTH-1:0]  MAX_VAL,
  input  logic [1:0]        MODE,
  input  logic              CLR_FLAGS,
  output logic [WIDTH-1:0]  COUNT,
  output logic              DIR,
  output logic              TC,
  output logic              OVF,
  output logic              UNF,
  output logic              AT_MAX,
  output logic              AT_MIN,
  output logic              CFG_ERR
);

  localparam int PAD = WIDTH + 1 - STEP_W;

  logic [WIDTH-1:0] count_q, count_d;
  logic             dir_q, dir_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic             ovf_set, unf_set;
  logic             is_wrap, is_bounce, eff_up;
  logic [WIDTH:0]   step_ext, sum, diff;
  logic             over, under;
  logic [WIDTH-1:0] load_clamped;

  assign CFG_ERR = (MIN_VAL > MAX_VAL);
  assign AT_MAX  = (COUNT == MAX_VAL);
  assign AT_MIN  = (COUNT == MIN_VAL);

  assign is_wrap = (MODE == 2'b01);
`ifdef UPDN_CNT_BOUNCE_EN
  assign is_bounce = (MODE == 2'b10);
`else
  assign is_bounce = 1'b0;
`endif

  // Bounce mode steers by the registered direction; all other modes follow UP_DWN.
  assign eff_up = is_bounce ? dir_q : UP_DWN;

  assign step_ext = {{PAD{1'b0}}, STEP};
  assign sum      = {1'b0, count_q} + step_ext;
  assign diff     = {1'b0, count_q} - step_ext;
  assign over     = (sum > {1'b0, MAX_VAL});
  assign under    = diff[WIDTH] | (diff[WIDTH-1:0] < MIN_VAL);

  assign load_clamped = (LOAD_VAL < MIN_VAL) ? MIN_VAL :
                        (LOAD_VAL > MAX_VAL) ? MAX_VAL : LOAD_VAL;

  always_comb begin
    count_d = count_q;
    dir_d   = dir_q;
    tc_d    = 1'b0;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    if (!CFG_ERR) begin
      if (LOAD) begin
        count_d = load_clamped;
        dir_d   = UP_DWN;
      end else if (EN) begin
        dir_d = is_bounce ? dir_q : UP_DWN;
        if (count_q < MIN_VAL) begin
          count_d = MIN_VAL;
        end else if (count_q > MAX_VAL) begin
          count_d = MAX_VAL;
        end else if (STEP != '0) begin
          if (eff_up) begin
            if (over) begin
              tc_d    = 1'b1;
              ovf_set = 1'b1;
              count_d = is_wrap ? MIN_VAL : MAX_VAL;
              if (is_bounce) dir_d = 1'b0;
            end else begin
              count_d = sum[WIDTH-1:0];
            end
          end else begin
            if (under) begin
              tc_d    = 1'b1;
              unf_set = 1'b1;
              count_d = is_wrap ? MAX_VAL : MIN_VAL;
              if (is_bounce) dir_d = 1'b1;
            end else begin
              count_d = diff[WIDTH-1:0];
            end
          end
        end
      end
    end
    // A flag being set this cycle takes precedence over a simultaneous clear.
    ovf_d = ovf_set | (ovf_q & ~CLR_FLAGS);
    unf_d = unf_set | (unf_q & ~CLR_FLAGS);
  end

  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) begin
      count_q <= '0;
      dir_q   <= 1'b1;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      dir_q   <= dir_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign COUNT = count_q;
  assign DIR   = dir_q;
  assign TC    = tc_q;
  assign OVF   = ovf_q;
  assign UNF   = unf_q;

endmodule

// File: tb/tb_param_updown_counter.sv
// tb/tb_param_updown_counter.sv - table-driven self-checking bench for param_updown_counter
module tb_param_updown_counter;

  logic       CLK = 1'b0;
  logic       N_RST;
  logic       EN, UP_DWN, LOAD, CLR_FLAGS;
  logic [7:0] LOAD_VAL, MIN_VAL, MAX_VAL;
  logic [3:0] STEP;
  logic [1:0] MODE;
  logic [7:0] COUNT;
  logic       DIR, TC, OVF, UNF, AT_MAX, AT_MIN, CFG_ERR;

  int n_checks = 0;
  int n_fail   = 0;

  param_updown_counter #(.WIDTH(8), .STEP_W(4)) dut (
    .CLK(CLK), .N_RST(N_RST), .EN(EN), .UP_DWN(UP_DWN), .LOAD(LOAD),
    .LOAD_VAL(LOAD_VAL), .STEP(STEP), .MIN_VAL(MIN_VAL), .MAX_VAL(MAX_VAL),
    .MODE(MODE), .CLR_FLAGS(CLR_FLAGS), .COUNT(COUNT), .DIR(DIR), .TC(TC),
    .OVF(OVF), .UNF(UNF), .AT_MAX(AT_MAX), .AT_MIN(AT_MIN), .CFG_ERR(CFG_ERR)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int load, lv, en, up, step, mn, mx, mode, clr;
    int e_cnt, e_dir, e_tc, e_ovf, e_unf, e_amax, e_amin, e_cfg;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input int load, input int lv, input int en, input int up, input int step,
                       input int mn, input int mx, input int mode, input int clr);
    LOAD = 1'(load); LOAD_VAL = 8'(lv); EN = 1'(en); UP_DWN = 1'(up); STEP = 4'(step);
    MIN_VAL = 8'(mn); MAX_VAL = 8'(mx); MODE = 2'(mode); CLR_FLAGS = 1'(clr);
  endtask

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  int b_cnt[6];
  int b_dir[6];
  int post_cnt;

  initial begin
    //          load lv  en up st mn mx  md clr | cnt dir tc ovf unf amax amin cfg
    vecs.push_back('{1, 253, 0, 1, 1, 0, 255, 0, 0,  253, 1, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{0, 0,   1, 1, 1, 0, 255, 0, 0,  254, 1, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{0, 0,   1, 1, 1, 0, 255, 0, 0,  255, 1, 0, 0, 0, 1, 0, 0});
    vecs.push_back('{0, 0,   1, 1, 1, 0, 255, 0, 0,  255, 1, 1, 1, 0, 1, 0, 0});
    vecs.push_back('{0, 0,   1, 1, 1, 0, 255, 0, 0,  255, 1, 1, 1, 0, 1, 0, 0});
    vecs.push_back('{0, 0,   1, 1, 1, 0, 255, 0, 1,  255, 1, 1, 1, 0, 1, 0, 0});
    vecs.push_back('{0, 0,   0, 1, 1, 0, 255, 0, 1,  255, 1, 0, 0, 0, 1, 0, 0});
    vecs.push_back('{1, 18,  0, 1, 4, 10, 20, 1, 0,  18,  1, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{0, 0,   1, 1, 4, 10, 20, 1, 0,  10,  1, 1, 1, 0, 0, 1, 0});
    vecs.push_back('{1, 11,  0, 0, 3, 10, 20, 1, 0,  11,  0, 0, 1, 0, 0, 0, 0});
    vecs.push_back('{0, 0,   1, 0, 3, 10, 20, 1, 0,  20,  0, 1, 1, 1, 1, 0, 0});
    vecs.push_back('{0, 0,   0, 0, 3, 10, 20, 1, 1,  20,  0, 0, 0, 0, 1, 0, 0});
    vecs.push_back('{0, 0,   1, 0, 15, 0, 20, 0, 0,  5,   0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{0, 0,   1, 0, 15, 0, 20, 0, 0,  0,   0, 1, 0, 1, 0, 1, 0});
    vecs.push_back('{1, 200, 1, 1, 1, 50, 100, 0, 1, 100, 1, 0, 0, 0, 1, 0, 0});
    vecs.push_back('{0, 0,   1, 1, 1, 50, 60, 0, 0,  60,  1, 0, 0, 0, 1, 0, 0});
    vecs.push_back('{0, 0,   1, 0, 0, 50, 60, 0, 0,  60,  0, 0, 0, 0, 1, 0, 0});
    vecs.push_back('{0, 0,   1, 0, 0, 50, 60, 0, 0,  60,  0, 0, 0, 0, 1, 0, 0});
    vecs.push_back('{0, 0,   1, 0, 0, 50, 60, 0, 0,  60,  0, 0, 0, 0, 1, 0, 0});
    vecs.push_back('{1, 5,   1, 1, 1, 9, 3,   0, 0,  60,  0, 0, 0, 0, 0, 0, 1});
    vecs.push_back('{0, 0,   1, 1, 1, 9, 3,   0, 0,  60,  0, 0, 0, 0, 0, 0, 1});
    vecs.push_back('{0, 0,   1, 1, 4, 0, 62,  3, 0,  62,  1, 1, 1, 0, 1, 0, 0});
    vecs.push_back('{0, 0,   0, 1, 4, 0, 62,  3, 0,  62,  1, 0, 1, 0, 1, 0, 0});

`ifdef UPDN_CNT_BOUNCE_EN
    b_cnt = '{4, 5, 3, 1, 0, 2};
    b_dir = '{1, 0, 0, 0, 1, 1};
    post_cnt = 0;
`else
    b_cnt = '{4, 5, 5, 5, 5, 5};
    b_dir = '{1, 1, 1, 1, 1, 1};
    post_cnt = 3;
`endif

    N_RST = 1'b0;
    drive(0, 0, 0, 1, 1, 0, 255, 0, 0);
    #12;
    chk("reset_count", int'(COUNT), 0);
    chk("reset_dir", int'(DIR), 1);
    chk("reset_tc", int'(TC), 0);
    chk("reset_ovf", int'(OVF), 0);
    chk("reset_unf", int'(UNF), 0);
    chk("reset_at_min", int'(AT_MIN), 1);
    @(negedge CLK);
    N_RST = 1'b1;

    foreach (vecs[i]) begin
      drive(vecs[i].load, vecs[i].lv, vecs[i].en, vecs[i].up, vecs[i].step,
            vecs[i].mn, vecs[i].mx, vecs[i].mode, vecs[i].clr);
      tick();
      chk($sformatf("v%0d_count", i), int'(COUNT), vecs[i].e_cnt);
      chk($sformatf("v%0d_dir", i), int'(DIR), vecs[i].e_dir);
      chk($sformatf("v%0d_tc", i), int'(TC), vecs[i].e_tc);
      chk($sformatf("v%0d_ovf", i), int'(OVF), vecs[i].e_ovf);
      chk($sformatf("v%0d_unf", i), int'(UNF), vecs[i].e_unf);
      chk($sformatf("v%0d_at_max", i), int'(AT_MAX), vecs[i].e_amax);
      chk($sformatf("v%0d_at_min", i), int'(AT_MIN), vecs[i].e_amin);
      chk($sformatf("v%0d_cfg_err", i), int'(CFG_ERR), vecs[i].e_cfg);
    end

    // Asynchronous reset in the middle of a cycle, with OVF set and COUNT nonzero.
    drive(0, 0, 1, 1, 1, 0, 62, 0, 0);
    #2;
    N_RST = 1'b0;
    #1;
    chk("async_rst_count", int'(COUNT), 0);
    chk("async_rst_ovf", int'(OVF), 0);
    chk("async_rst_dir", int'(DIR), 1);
    chk("async_rst_at_min", int'(AT_MIN), 1);
    tick();
    chk("rst_held_count", int'(COUNT), 0);
    N_RST = 1'b1;
    tick();
    chk("post_rst_count", int'(COUNT), 1);

    // Bounce sequence; without the macro MODE 10 saturates.
    drive(1, 2, 0, 1, 2, 0, 5, 2, 0);
    tick();
    chk("bounce_load", int'(COUNT), 2);
    drive(0, 0, 1, 1, 2, 0, 5, 2, 0);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("bounce%0d_count", k), int'(COUNT), b_cnt[k]);
      chk($sformatf("bounce%0d_dir", k), int'(DIR), b_dir[k]);
    end
    drive(0, 0, 1, 0, 2, 0, 5, 0, 0);
    tick();
    chk("leave_bounce_dir", int'(DIR), 0);
    chk("leave_bounce_count", int'(COUNT), post_cnt);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/param_updown_counter.md
# param_updown_counter

Parametrised up/down counter: the next-generation replacement for the fixed 4-bit saturating counter in the lab datapath. It adds a configurable width, a runtime step size, programmable MIN/MAX bounds, synchronous load, saturate, wrap and bounce modes, and sticky overflow/underflow flags. It serves as a general event, timer or address counter for later experiments.

## Interface
Parameters:
- WIDTH, 8, count width in bits (≥2)
- STEP_W, 4, width of the STEP input (≥1, ≤WIDTH)

Ports:
- CLK  in  1  clock, all state updates on rising edge
- N_RST  in  1  reset; one clock; reset is asynchronous and active-low
- EN  in  1  count enable
- UP_DWN  in  1  requested direction, 1 = up, 0 = down
- LOAD  in  1  synchronous load, priority over EN
- LOAD_VAL  in  WIDTH  value for LOAD
- STEP  in  STEP_W  unsigned increment/decrement per enabled cycle
- MIN_VAL  in  WIDTH  lower bound, inclusive
- MAX_VAL  in  WIDTH  upper bound, inclusive
- MODE  in  2  bound behaviour: 00 saturate, 01 wrap, 10 bounce, 11 treated as 00
- CLR_FLAGS  in  1  clears OVF/UNF
- COUNT  out  WIDTH  registered count
- DIR  out  1  registered effective direction
- TC  out  1  registered one-cycle pulse, a bound event was taken last cycle
- OVF  out  1  sticky, upper-bound event occurred
- UNF  out  1  sticky, lower-bound event occurred
- AT_MAX  out  1  combinational, COUNT == MAX_VAL
- AT_MIN  out  1  combinational, COUNT == MIN_VAL
- CFG_ERR  out  1  combinational, MIN_VAL > MAX_VAL

## Operation
- Unsigned arithmetic in WIDTH+1 bits. No silent modular wrap ever reaches COUNT.
- Cycle priority: reset > CFG_ERR (hold COUNT, no events) > LOAD > EN > hold.
- LOAD: COUNT ← LOAD_VAL clamped to [MIN_VAL, MAX_VAL]. DIR ← UP_DWN. No TC, no flags.
- EN with COUNT outside [MIN_VAL, MAX_VAL] (bounds changed at runtime): COUNT ← nearest bound. No step, no flags, no TC.
- EN with STEP == 0: COUNT is held, with no events.
- Outside bounce mode, DIR ← UP_DWN every EN cycle.
- Up step, nxt = COUNT + STEP:
  - nxt ≤ MAX_VAL: COUNT ← nxt. Reaching MAX exactly is not an event.
  - nxt > MAX_VAL: upper-bound event. OVF ← 1, TC ← 1.
  - Saturate mode: COUNT ← MAX_VAL. Wrap mode: COUNT ← MIN_VAL. Bounce mode: COUNT ← MAX_VAL, DIR ← 0.
- Down step, nxt = COUNT − STEP, underflow detected on the borrow bit or nxt < MIN_VAL:
  - Mirror of the up step with UNF set.
  - Saturate mode: COUNT ← MIN_VAL. Wrap mode: COUNT ← MAX_VAL. Bounce mode: COUNT ← MIN_VAL, DIR ← 1.
- Bounce mode uses the internal DIR to choose the step direction and ignores UP_DWN (except on LOAD).
- Repeated saturation hits are events every cycle: TC stays high and the flag re-sets each cycle.
- CLR_FLAGS clears OVF and UNF. A set in the same cycle wins over the clear.
- TC is 0 in any cycle without an event.
- Mode changes take effect on the next edge. A DIR value from bounce mode is overwritten by UP_DWN on the first EN cycle after leaving bounce.

## Timing
- Reset values: COUNT = 0, DIR = 1, TC = 0, OVF = 0, UNF = 0.
- AT_MAX, AT_MIN and CFG_ERR follow their inputs combinationally, including during reset.
- Reset asserted mid-count clears all registers immediately, with no clock needed. Counting resumes on the first edge after deassertion.
- Latency: inputs sampled at edge k; COUNT, DIR, TC and flags are valid after edge k.
- TC is high for exactly the cycle following each event edge.
- No handshake. EN may be held for any duration, and all control inputs may change every cycle.
- Bound and step inputs are sampled each edge and need not be stable between edges.

## Configuration
- Macro: UPDN_CNT_BOUNCE_EN.
- Defined: MODE 10 gives bounce behaviour as described above.
- Undefined: MODE 10 behaves exactly as saturate, DIR always equals the UP_DWN sampled at the last LOAD/EN edge, and the bounce logic is not synthesised.

## Test plan
- Reset and saturation: WIDTH=8, MIN=0, MAX=255, MODE=00, STEP=1, UP_DWN=1, load 253, EN for 4 cycles → COUNT 254, 255, 255, 255; OVF=1 after the third edge; TC high after edges 3 and 4. Assert N_RST low mid-run → COUNT=0, OVF=0 asynchronously.
- Wrap with step: MIN=10, MAX=20, MODE=01, STEP=4, load 18, up → COUNT 10, TC=1, OVF=1. Then down with STEP=3 from 11 → COUNT 20, UNF=1. CLR_FLAGS with no event → OVF=UNF=0.
- Bounce (macro defined): MIN=0, MAX=5, MODE=10, STEP=2, load 2 with UP_DWN=1, EN for 6 cycles → COUNT 4, 5, 3, 1, 0, 2; DIR 1, 0, 0, 0, 1, 1. Same stimulus with the macro undefined → 4, 5, 5, 5, 5, 5.
- Load clamp and out-of-range: MIN=50, MAX=100, LOAD=1 with LOAD_VAL=200 and EN=1 → COUNT=100, no TC. Then MAX=60 with EN → COUNT=60, no flags.
- Config error and priority: MIN=9, MAX=3 → CFG_ERR=1, and COUNT is held under LOAD and EN. CLR_FLAGS in the same cycle as an overflow → OVF stays 1.
- STEP=0 with EN for 3 cycles → COUNT unchanged, TC=0.
